// File: rtl/ars_mixcol_arbiter_pkg.sv
// Shared AES definitions for the mix-column arbiter: block width, FSM encodings,
// default ready timeout and a small owner-decode helper.
package ars_mixcol_arbiter_pkg;

  localparam int unsigned AES_W          = 128;
  localparam int unsigned MC_TIMEOUT_DEF = 15;

  typedef logic [AES_W-1:0] aes_block_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ars_mixcol_arbiter_if.sv
// Requester and mix-column unit signals of the arbiter. The slave modport is the
// arbiter itself; the master modport is its environment (requesters + unit).
interface ars_mixcol_arbiter_if;
  import ars_mixcol_arbiter_pkg::*;

  logic [1:0] req_i;
  logic [1:0] req_decrypt_i;
  aes_block_t req_data0_i;
  aes_block_t req_data1_i;
  logic [1:0] gnt_o;
  logic [1:0] done_o;
  aes_block_t res_data_o;
  logic       err_o;

  logic       mc_start_o;
  logic       mc_decrypt_o;
  aes_block_t mc_data_o;
  logic       mc_ready_i;
  aes_block_t mc_data_i;

  modport slave (
    input  req_i, req_decrypt_i, req_data0_i, req_data1_i, mc_ready_i, mc_data_i,
    output gnt_o, done_o, res_data_o, err_o, mc_start_o, mc_decrypt_o, mc_data_o
  );

  modport master (
    output req_i, req_decrypt_i, req_data0_i, req_data1_i, mc_ready_i, mc_data_i,
    input  gnt_o, done_o, res_data_o, err_o, mc_start_o, mc_decrypt_o, mc_data_o
  );

endinterface

// File: rtl/ars_rr_arb2.sv
// Two-way round-robin selector: a lone request wins, a tie goes to the requester
// that did not win last time.
module ars_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
    else                gnt_o = req_i;
  end

endmodule

// File: rtl/ars_mixcol_arbiter.sv
// Shares one external mix-column unit between two requesters, one transaction at a
// time, with a ready timeout that reports a sticky error and returns a zero result.
module ars_mixcol_arbiter
  import ars_mixcol_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = MC_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  ars_mixcol_arbiter_if.slave  bus
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q,  last_d;
  logic       dec_q,   dec_d;
  aes_block_t op_q,    op_d;
  aes_block_t res_q,   res_d;
  logic       err_q,   err_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [1:0] arb_gnt;
  logic       busy;

  ars_rr_arb2 u_rr_arb2 (
    .req_i  (bus.req_i),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // NOTE: every _d starts from its _q so no path through the case leaves a
  // variable unassigned; that is what keeps this block free of latches.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    dec_d   = dec_q;
    op_d    = op_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req_i) begin
          owner_d = arb_gnt[1];
          op_d    = ({AES_W{arb_gnt[0]}} & bus.req_data0_i) |
                    ({AES_W{arb_gnt[1]}} & bus.req_data1_i);
          dec_d   = |(arb_gnt & bus.req_decrypt_i);
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // A ready arriving in the timeout cycle still counts as a normal completion.
        if (bus.mc_ready_i) begin
          res_d   = bus.mc_data_i;
          state_d = ST_DONE;
        end else if (cnt_d == TO_CNT) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the latched operand is reset along with the control state; the bus is
  // gated to zero outside ISSUE/WAIT anyway, but a known value keeps sims X-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // "requester 1 won last" gives requester 0 the first tie
      dec_q   <= 1'b0;
      op_q    <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values.
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      dec_q   <= dec_d;
      op_q    <= op_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // The unit reads the operand one word per cycle, so hold it for all of ISSUE..WAIT.
  assign busy             = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign bus.gnt_o        = (state_q == ST_ISSUE) ? owner_onehot(owner_q) : 2'b00;
  assign bus.done_o       = (state_q == ST_DONE)  ? owner_onehot(owner_q) : 2'b00;
  assign bus.mc_start_o   = (state_q == ST_ISSUE);
  assign bus.mc_data_o    = busy ? op_q : '0;
  assign bus.mc_decrypt_o = busy & dec_q;
  assign bus.res_data_o   = res_q;
  assign bus.err_o        = err_q;

endmodule

// File: doc/ars_mixcol_arbiter.md
ARS_MIXCOL_ARBITER -- requirements
Module: ARS_mixcol_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: WAIT cycles allowed before mc_ready_i is declared missing (range 5..255).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_i  input  2  per-requester level request, bit n = requester n.
REQ-005 SHALL have port req_decrypt_i  input  2  per-requester mode, 1 = inverse mix column.
REQ-006 SHALL have ports req_data0_i, req_data1_i  input  128  operand per requester.
REQ-007 SHALL have port gnt_o  output  2  one-hot one-cycle grant pulse; operand sampled in that cycle.
REQ-008 SHALL have port done_o  output  2  one-hot one-cycle completion pulse to owner.
REQ-009 SHALL have port res_data_o  output  128  result, valid while done_o != 0, held until next completion.
REQ-010 SHALL have port err_o  output  1  sticky timeout flag.
REQ-011 SHALL have ports mc_start_o  output  1, mc_decrypt_o  output  1, mc_data_o  output  128: drive the shared mix-column unit.
REQ-012 SHALL have ports mc_ready_i  input  1, mc_data_i  input  128: mix-column completion and result.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, one transaction at a time.
REQ-014 IDLE: if req_i != 0, SHALL select owner, latch owner's data/decrypt into internal registers, go ISSUE next cycle; else stay.
REQ-015 Arbitration SHALL be round-robin: single request wins; both requesting -> requester not served last wins; after reset requester 0 has priority.
REQ-016 ISSUE (exactly one cycle): gnt_o[owner]=1, mc_start_o=1; go WAIT.
REQ-017 mc_data_o and mc_decrypt_o SHALL equal the latched operand/mode from ISSUE through end of WAIT (unit samples operand words over 4 cycles), and 0 in IDLE/DONE.
REQ-018 WAIT: mc_start_o=0; 8-bit counter increments each cycle; on mc_ready_i=1 capture mc_data_i into res_data_o, go DONE.
REQ-019 WAIT: counter reaching TIMEOUT without mc_ready_i SHALL set err_o, load res_data_o with 0, go DONE.
REQ-020 DONE (one cycle): done_o[owner]=1; update round-robin pointer to owner; go IDLE.
REQ-021 Latency with standard unit (ready 4 cycles after start cycle): req seen in IDLE cycle T -> gnt_o at T+1, mc_ready_i at T+5, done_o at T+6, next ISSUE no earlier than T+8.
REQ-022 mc_ready_i outside WAIT SHALL be ignored; mc_ready_i and timeout in same cycle -> ready wins, err_o unchanged.
REQ-023 Requests withdrawn before grant SHALL be ignored; req_i changes after grant SHALL not affect the running transaction.
REQ-024 gnt_o, done_o SHALL never have more than one bit set and never both nonzero in the same cycle.
REQ-025 err_o SHALL remain 1 until reset; arbiter continues serving after error.

Reset
REQ-026 reset low SHALL immediately force state IDLE, gnt_o=0, done_o=0, res_data_o=0, err_o=0, mc_start_o=0, mc_decrypt_o=0, mc_data_o=0, counter=0, pointer favouring requester 0.
REQ-027 Reset mid-transaction SHALL abandon it with no done_o pulse; mix-column unit shares the same reset.

Structure
REQ-028 FSM state encodings (2-bit) and default TIMEOUT SHALL live in the shared AES package; operand width 128 taken from same package.
REQ-029 Round-robin selection SHALL be one sub-module ARS_rr_arb2 (2 requests, last-winner input, one-hot grant); mix-column unit is instantiated outside this block.

Verification
REQ-030 Single request: req_i=01, data0=0xdb135345_f20a225c_01010101_c6c6c6c6, decrypt=0 -> gnt_o=01 at T+1, done_o=01 at T+6, res=0x8e4da1bc_9fdc589d_01010101_c6c6c6c6.
REQ-031 Decrypt round-trip: feed result of REQ-030 with decrypt=1 -> res equals original operand, err_o=0.
REQ-032 Contention: req_i=11 held for 3 transactions -> grant order 0,1,0; each done_o to correct owner.
REQ-033 Timeout: stub unit never asserts ready, TIMEOUT=15 -> done_o at 15 WAIT cycles, res=0, err_o=1 sticky; next request still completes.
REQ-034 Reset asserted in WAIT -> all outputs 0 same cycle, no done_o; post-reset request to requester 1 then 0 both-pending -> requester 0 first.
REQ-035 Operand stability: change req_data0_i every cycle after grant -> mc_data_o constant ISSUE..WAIT, result matches latched operand.
